// File: rtl/pipeline_pkg.sv
// Shared types for the 5-stage pipeline hazard controller.
// Register width, forwarding-select encodings, in-flight slot record.
package pipeline_pkg;

  localparam int REG_AW = 3;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_WBREG = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              writes_rd;
    logic              is_load;
  } hz_slot_t;

  function automatic logic hit(
    hz_slot_t          s,
    logic [REG_AW-1:0] idx,
    logic              used,
    logic              id_valid
  );
    return s.valid && s.writes_rd &&
           id_valid && used &&
           (idx == s.rd);
  endfunction

endpackage

// File: rtl/mc_busy_counter.sv
// Multi-cycle EX occupancy counter: load MC_LAT-1, count down to 0.
// Ports: clk, reset (async high), load, busy (count != 0).
module mc_busy_counter #(
  parameter int MC_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic busy
);

  logic [3:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= 4'(MC_LAT - 1);
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign busy = (cnt != 4'd0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: tracks EX/MEM/WB destinations, drives forwarding,
// stalls (load-use, RAW without forwarding, multi-cycle EX) and flushes.
// Ports: clk, reset, decoded ID fields, ex_branch_taken in;
// stall_pc, stall_id, bubble_ex, flush_id, bubble_mem,
// fwd_sel_a/b (registered), ex_busy out.
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_writes_rd,
  input  logic              id_is_load,
  input  logic              id_is_multi,
  input  logic              ex_branch_taken,
  output logic              stall_pc,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_id,
  output logic              bubble_mem,
  output logic [1:0]        fwd_sel_a,
  output logic [1:0]        fwd_sel_b,
  output logic              ex_busy
);

  hz_slot_t ex_s, mem_s, wb_s, id_s;
  fwd_sel_t sel_a, sel_b;
  fwd_sel_t sel_a_q, sel_b_q;

  logic a_ex, a_mem, a_wb;
  logic b_ex, b_mem, b_wb;
  logic load_use, raw_stall;
  logic take_br, enter;

  assign a_ex  = hit(ex_s,  id_rs1, id_rs1_used, id_valid);
  assign a_mem = hit(mem_s, id_rs1, id_rs1_used, id_valid);
  assign a_wb  = hit(wb_s,  id_rs1, id_rs1_used, id_valid);
  assign b_ex  = hit(ex_s,  id_rs2, id_rs2_used, id_valid);
  assign b_mem = hit(mem_s, id_rs2, id_rs2_used, id_valid);
  assign b_wb  = hit(wb_s,  id_rs2, id_rs2_used, id_valid);

  assign load_use = ex_s.is_load && (a_ex || b_ex);

  // Without forwarding the consumer waits until the producer leaves WB.
  assign raw_stall = FWD_EN ? load_use
                   : (a_ex || a_mem || a_wb ||
                      b_ex || b_mem || b_wb);

  // A branch can never resolve while a multi-cycle op holds EX.
  assign take_br = ex_branch_taken && !ex_busy;

  always_comb begin
    stall_pc   = 1'b0;
    stall_id   = 1'b0;
    bubble_ex  = 1'b0;
    flush_id   = 1'b0;
    bubble_mem = 1'b0;
    if (ex_busy) begin
      stall_pc   = 1'b1;
      stall_id   = 1'b1;
      bubble_mem = 1'b1;
    end else if (take_br) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (raw_stall) begin
      stall_pc  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    if (FWD_EN) begin
      if (a_ex)       sel_a = FWD_EXMEM;
      else if (a_mem) sel_a = FWD_MEMWB;
      else if (a_wb)  sel_a = FWD_WBREG;
      if (b_ex)       sel_b = FWD_EXMEM;
      else if (b_mem) sel_b = FWD_MEMWB;
      else if (b_wb)  sel_b = FWD_WBREG;
    end
  end

  assign enter = id_valid && !bubble_ex &&
                 !stall_pc && !flush_id;

  always_comb begin
    id_s           = '0;
    id_s.valid     = 1'b1;
    id_s.rd        = id_rd;
    id_s.writes_rd = id_writes_rd;
    id_s.is_load   = id_is_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_s    <= '0;
      mem_s   <= '0;
      wb_s    <= '0;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
    end else if (!ex_busy) begin
      ex_s    <= enter ? id_s : '0;
      mem_s   <= ex_s;
      wb_s    <= mem_s;
      sel_a_q <= enter ? sel_a : FWD_RF;
      sel_b_q <= enter ? sel_b : FWD_RF;
    end
  end

  assign fwd_sel_a = sel_a_q;
  assign fwd_sel_b = sel_b_q;

  mc_busy_counter #(
    .MC_LAT (MC_LAT)
  ) u_mc (
    .clk   (clk),
    .reset (reset),
    .load  (enter && id_is_multi),
    .busy  (ex_busy)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (forwarding and no-forwarding
// instances driven by one stimulus stream).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [2:0] id_rs1, id_rs2, id_rd;
  logic       id_rs1_used, id_rs2_used;
  logic       id_writes_rd, id_is_load, id_is_multi;
  logic       ex_branch_taken;

  logic       stall_pc, stall_id, bubble_ex;
  logic       flush_id, bubble_mem, ex_busy;
  logic [1:0] fwd_sel_a, fwd_sel_b;

  logic       n_stall_pc, n_stall_id, n_bubble_ex;
  logic       n_flush_id, n_bubble_mem, n_ex_busy;
  logic [1:0] n_fwd_sel_a, n_fwd_sel_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .MC_LAT (4),
    .FWD_EN (1'b1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_writes_rd    (id_writes_rd),
    .id_is_load      (id_is_load),
    .id_is_multi     (id_is_multi),
    .ex_branch_taken (ex_branch_taken),
    .stall_pc        (stall_pc),
    .stall_id        (stall_id),
    .bubble_ex       (bubble_ex),
    .flush_id        (flush_id),
    .bubble_mem      (bubble_mem),
    .fwd_sel_a       (fwd_sel_a),
    .fwd_sel_b       (fwd_sel_b),
    .ex_busy         (ex_busy)
  );

  pipeline_hazard_ctrl #(
    .MC_LAT (4),
    .FWD_EN (1'b0)
  ) dut_nf (
    .clk             (clk),
    .reset           (reset),
    .id_valid        (id_valid),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .id_rd           (id_rd),
    .id_writes_rd    (id_writes_rd),
    .id_is_load      (id_is_load),
    .id_is_multi     (id_is_multi),
    .ex_branch_taken (ex_branch_taken),
    .stall_pc        (n_stall_pc),
    .stall_id        (n_stall_id),
    .bubble_ex       (n_bubble_ex),
    .flush_id        (n_flush_id),
    .bubble_mem      (n_bubble_mem),
    .fwd_sel_a       (n_fwd_sel_a),
    .fwd_sel_b       (n_fwd_sel_b),
    .ex_busy         (n_ex_busy)
  );

  // A taken branch must never coincide with a busy multi-cycle EX.
  always @(negedge clk) begin
    if (!reset) begin
      assert (!(ex_branch_taken && ex_busy))
      else begin
        errors++;
        $error("FAIL br_busy: branch while ex_busy");
      end
    end
  end

  task automatic chk(string tag, logic [1:0] obs,
                     logic [1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic drive(logic v,
                       logic [2:0] r1, logic u1,
                       logic [2:0] r2, logic u2,
                       logic [2:0] rd, logic wr,
                       logic ld, logic mc, logic br);
    id_valid        = v;
    id_rs1          = r1;
    id_rs1_used     = u1;
    id_rs2          = r2;
    id_rs2_used     = u2;
    id_rd           = rd;
    id_writes_rd    = wr;
    id_is_load      = ld;
    id_is_multi     = mc;
    ex_branch_taken = br;
    #3;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_stall_pc"}, {1'b0, stall_pc}, 2'd0);
    chk({tag, "_stall_id"}, {1'b0, stall_id}, 2'd0);
    chk({tag, "_bubble_ex"}, {1'b0, bubble_ex}, 2'd0);
    chk({tag, "_flush_id"}, {1'b0, flush_id}, 2'd0);
    chk({tag, "_bubble_mem"}, {1'b0, bubble_mem}, 2'd0);
    chk({tag, "_ex_busy"}, {1'b0, ex_busy}, 2'd0);
    chk({tag, "_sel_a"}, fwd_sel_a, 2'd0);
    chk({tag, "_sel_b"}, fwd_sel_b, 2'd0);
  endtask

  initial begin
    reset = 1'b1;
    nop();
    chk_all_zero("rst");
    tick();
    tick();
    reset = 1'b0;

    // 1: ADD r1,r2,r3 ; SUB r4,r1,r5
    drive(1, 2, 1, 3, 1, 1, 1, 0, 0, 0);
    chk("t1_add_stall", {1'b0, stall_pc}, 2'd0);
    tick();
    drive(1, 1, 1, 5, 1, 4, 1, 0, 0, 0);
    chk("t1_sub_stall", {1'b0, stall_pc}, 2'd0);
    chk("t1_sub_bub", {1'b0, bubble_ex}, 2'd0);
    tick();
    chk("t1_sel_a", fwd_sel_a, 2'd1);
    chk("t1_sel_b", fwd_sel_b, 2'd0);

    // 2: LD r2 ; ADD r3,r2,r2
    drive(1, 6, 1, 0, 0, 2, 1, 1, 0, 0);
    tick();
    drive(1, 2, 1, 2, 1, 3, 1, 0, 0, 0);
    chk("t2_lu_stall", {1'b0, stall_pc}, 2'd1);
    chk("t2_lu_bub", {1'b0, bubble_ex}, 2'd1);
    tick();
    drive(1, 2, 1, 2, 1, 3, 1, 0, 0, 0);
    chk("t2_go_stall", {1'b0, stall_pc}, 2'd0);
    chk("t2_go_bub", {1'b0, bubble_ex}, 2'd0);
    tick();
    chk("t2_sel_a", fwd_sel_a, 2'd2);
    chk("t2_sel_b", fwd_sel_b, 2'd2);

    // 3: MUL r1,r6,r6 ; ADD r5,r1,r0
    drive(1, 6, 1, 6, 1, 1, 1, 0, 1, 0);
    chk("t3_mul_stall", {1'b0, stall_pc}, 2'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 0, 1, 5, 1, 0, 0, 0);
      chk("t3_busy", {1'b0, ex_busy}, 2'd1);
      chk("t3_stall_pc", {1'b0, stall_pc}, 2'd1);
      chk("t3_stall_id", {1'b0, stall_id}, 2'd1);
      chk("t3_bub_mem", {1'b0, bubble_mem}, 2'd1);
      chk("t3_bub_ex", {1'b0, bubble_ex}, 2'd0);
      tick();
    end
    drive(1, 1, 1, 0, 1, 5, 1, 0, 0, 0);
    chk("t3_done_busy", {1'b0, ex_busy}, 2'd0);
    chk("t3_done_stall", {1'b0, stall_pc}, 2'd0);
    tick();
    chk("t3_sel_a", fwd_sel_a, 2'd1);
    chk("t3_sel_b", fwd_sel_b, 2'd0);

    // 4: LD r6 in EX, branch taken with load-use in ID
    drive(1, 0, 0, 0, 0, 6, 1, 1, 0, 0);
    tick();
    drive(1, 6, 1, 0, 0, 4, 1, 0, 0, 1);
    chk("t4_flush", {1'b0, flush_id}, 2'd1);
    chk("t4_bub_ex", {1'b0, bubble_ex}, 2'd1);
    chk("t4_stall_pc", {1'b0, stall_pc}, 2'd0);
    tick();
    nop();
    tick();
    // r4 producer was killed; LD r6 now in WB
    drive(1, 4, 1, 6, 1, 7, 1, 0, 0, 0);
    chk("t4_rd_stall", {1'b0, stall_pc}, 2'd0);
    tick();
    chk("t4_sel_a", fwd_sel_a, 2'd0);
    chk("t4_sel_b", fwd_sel_b, 2'd3);

    // 5: r7 in WB, r0 in MEM
    drive(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(1, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tick();
    drive(1, 7, 1, 0, 1, 1, 1, 0, 0, 0);
    chk("t5_stall", {1'b0, stall_pc}, 2'd0);
    tick();
    chk("t5_sel_a", fwd_sel_a, 2'd3);
    chk("t5_sel_b", fwd_sel_b, 2'd2);

    // 6: reset in the middle of a multi-cycle op
    drive(1, 0, 0, 0, 0, 3, 1, 0, 1, 0);
    tick();
    nop();
    tick();
    chk("t6_pre_busy", {1'b0, ex_busy}, 2'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("t6_rst");
    tick();
    reset = 1'b0;
    drive(1, 3, 1, 1, 1, 4, 1, 0, 0, 0);
    chk("t6_stall", {1'b0, stall_pc}, 2'd0);
    chk("t6_busy", {1'b0, ex_busy}, 2'd0);
    tick();
    chk("t6_sel_a", fwd_sel_a, 2'd0);
    chk("t6_sel_b", fwd_sel_b, 2'd0);

    // 7: no-forwarding instance, back-to-back RAW
    reset = 1'b1;
    nop();
    tick();
    reset = 1'b0;
    drive(1, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    tick();
    drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0);
    chk("t7_fwd_stall", {1'b0, stall_pc}, 2'd0);
    for (int i = 0; i < 3; i++) begin
      chk("t7_nf_stall", {1'b0, n_stall_pc}, 2'd1);
      chk("t7_nf_bub", {1'b0, n_bubble_ex}, 2'd1);
      tick();
      drive(1, 4, 1, 0, 0, 5, 1, 0, 0, 0);
    end
    chk("t7_nf_go", {1'b0, n_stall_pc}, 2'd0);
    tick();
    chk("t7_nf_sel_a", n_fwd_sel_a, 2'd0);
    nop();
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
